// File: rtl/frame_writer_pkg.sv
// Shared types and constants for the frame writer slice.
package frame_writer_pkg;

    localparam int FW_MAX_DIM = 1024;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color_t;

    typedef enum logic [1:0] {
        FW_IDLE  = 2'd0,
        FW_RUN   = 2'd1,
        FW_DRAIN = 2'd2,
        FW_DONE  = 2'd3
    } fw_state_t;

endpackage

// File: rtl/frame_writer_fifo.sv
// Synchronous FIFO with a registered read port: dout always holds the current head,
// so a word pushed into an empty FIFO is visible the following cycle.
module pixel_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Flags come from registered occupancy only, so a push into a full FIFO is
    // refused even when a pop happens in the same cycle.
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_next = rd_ptr + PTR_W'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_next;
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            // The new head is the incoming word only when it lands in the head slot.
            if (do_push && (wr_ptr == rd_next)) begin
                dout <= din;
            end else begin
                dout <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/frame_writer.sv
// Frame writer: buffers a raster pixel stream and writes it to word-addressed memory.
// Defining FRAME_WRITER_CHECKSUM_EN adds frame_checksum, the sum of all written pixels.
module frame_writer
    import frame_writer_pkg::*;
#(
    parameter int  MAX_DIM    = FW_MAX_DIM,
    parameter int  FIFO_DEPTH = 16,
    parameter int  ADDR_W     = 20,
    localparam int DIM_W      = $clog2(MAX_DIM + 1),
    localparam int CNT_W      = $clog2(MAX_DIM * MAX_DIM + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  img_height,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  color_t            color_in,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output color_t            mem_wr_data,
    input  logic              mem_wr_ack,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output fw_state_t         state_dbg
`ifdef FRAME_WRITER_CHECKSUM_EN
    ,
    output logic [31:0]       frame_checksum
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

    logic [1:0]        state;
    logic [DIM_W-1:0]  cfg_h;
    logic [DIM_W-1:0]  cfg_w;
    logic [ADDR_W-1:0] cfg_base;
    logic [DIM_W-1:0]  in_row;
    logic [DIM_W-1:0]  in_col;
    logic [DIM_W-1:0]  out_row;
    logic [DIM_W-1:0]  out_col;
    logic [CNT_W-1:0]  out_count;

    logic   active;
    logic   cfg_bad;
    logic   start_ok;
    logic   push;
    logic   pop;
    logic   in_last;
    logic   out_last;
    logic   fifo_full;
    logic   fifo_empty;
    color_t fifo_dout;

    // Handshakes: a pixel moves when pix_valid && pix_ready in the same cycle;
    // a write completes when mem_wr_req && mem_wr_ack, and req/addr/data hold until then.
    assign active    = (state == ST_RUN) || (state == ST_DRAIN);
    assign cfg_bad   = (img_height == '0) || (img_width == '0);
    assign start_ok  = (state == ST_IDLE) && start && !cfg_bad;
    assign pix_ready = (state == ST_RUN) && !fifo_full;
    assign push      = pix_valid && pix_ready;
    assign mem_wr_req = active && !fifo_empty;
    assign pop       = mem_wr_req && mem_wr_ack;

    assign in_last  = (in_row == cfg_h - DIM_ONE) && (in_col == cfg_w - DIM_ONE);
    assign out_last = (out_row == cfg_h - DIM_ONE) && (out_col == cfg_w - DIM_ONE);

    // Outputs are forced to zero while no write is pending so idle values are clean.
    assign mem_wr_addr = mem_wr_req ? (cfg_base + ADDR_W'(out_count)) : '0;
    assign mem_wr_data = mem_wr_req ? fifo_dout : '0;

    assign busy      = active;
    assign done      = (state == ST_DONE);
    assign state_dbg = fw_state_t'(state);

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (color_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (color_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cfg_h     <= '0;
            cfg_w     <= '0;
            cfg_base  <= '0;
            in_row    <= '0;
            in_col    <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_count <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && cfg_bad) begin
                        cfg_err <= 1'b1;
                    end else if (start_ok) begin
                        cfg_h     <= img_height;
                        cfg_w     <= img_width;
                        cfg_base  <= base_addr;
                        in_row    <= '0;
                        in_col    <= '0;
                        out_row   <= '0;
                        out_col   <= '0;
                        out_count <= '0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (push && in_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && out_last) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (push) begin
                if (in_col == cfg_w - DIM_ONE) begin
                    in_col <= '0;
                    in_row <= in_row + DIM_ONE;
                end else begin
                    in_col <= in_col + DIM_ONE;
                end
            end

            // out_count is the raster index row*W+col, advanced one step per ack.
            if (pop) begin
                out_count <= out_count + CNT_W'(1);
                if (out_col == cfg_w - DIM_ONE) begin
                    out_col <= '0;
                    out_row <= out_row + DIM_ONE;
                end else begin
                    out_col <= out_col + DIM_ONE;
                end
            end
        end
    end

`ifdef FRAME_WRITER_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else if (start_ok) begin
            checksum_q <= '0;
        end else if (pop) begin
            checksum_q <= checksum_q + {8'd0, fifo_dout};
        end
    end

    assign frame_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer: randomized frames checked against a raster-order write model.
module tb_frame_writer;
    import frame_writer_pkg::*;

    localparam int ADDR_W = 20;
    localparam int DIM_W  = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DIM_W-1:0]  img_height;
    logic [DIM_W-1:0]  img_width;
    logic [ADDR_W-1:0] base_addr;
    logic              pix_valid;
    logic              pix_ready;
    color_t            color_in;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_wr_addr;
    color_t            mem_wr_data;
    logic              mem_wr_ack;
    logic              busy;
    logic              done;
    logic              cfg_err;
    fw_state_t         state_dbg;
`ifdef FRAME_WRITER_CHECKSUM_EN
    logic [31:0]       frame_checksum;
`endif

    frame_writer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .img_height  (img_height),
        .img_width   (img_width),
        .base_addr   (base_addr),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .color_in    (color_in),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_ack  (mem_wr_ack),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .state_dbg   (state_dbg)
`ifdef FRAME_WRITER_CHECKSUM_EN
        ,
        .frame_checksum (frame_checksum)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;

    logic [23:0]       exp_q[$];      // pixels accepted, in order = expected write data
    logic [ADDR_W-1:0] obs_addr_q[$];
    logic [23:0]       obs_data_q[$];
    int accepted, done_cnt, done_cyc, last_ack, first_ack, cfgerr_cnt, stab_err;
    int stall_accepts;
    logic busy_at_done, ready_first, ready_at_stall_end;

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        start = 1'b0; pix_valid = 1'b0; mem_wr_ack = 1'b0;
        color_in = '0; img_height = '0; img_width = '0; base_addr = '0;
    endtask

    task automatic drive_frame(input int h, input int w, input int base,
                               input int valid_pct, input int ack_pct, input int stall,
                               input bit hold_valid, input bit extra_start, input bit seq_pix);
        logic [23:0]       cur_pix;
        logic              pend;
        logic [ADDR_W-1:0] p_addr;
        logic [23:0]       p_data;
        int cyc;
        exp_q.delete(); obs_addr_q.delete(); obs_data_q.delete();
        accepted = 0; done_cnt = 0; done_cyc = -1; last_ack = -1; first_ack = -1;
        cfgerr_cnt = 0; stab_err = 0; stall_accepts = -1; pend = 1'b0;
        p_addr = '0; p_data = '0;
        cur_pix = seq_pix ? 24'd1 : 24'($urandom);
        @(posedge clk); #1;
        start = 1'b1; img_height = DIM_W'(h); img_width = DIM_W'(w); base_addr = ADDR_W'(base);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 3000) begin
            pix_valid  = hold_valid || ($urandom_range(99) < valid_pct);
            color_in   = cur_pix;
            mem_wr_ack = (cyc >= stall) && ($urandom_range(99) < ack_pct);
            start      = extra_start && (cyc == 3);
            img_height = (start) ? DIM_W'(1) : DIM_W'(h);
            img_width  = (start) ? DIM_W'(1) : DIM_W'(w);
            if (cyc == 0) ready_first = pix_ready;
            if (cyc == stall && stall > 0) begin
                stall_accepts = accepted;
                ready_at_stall_end = pix_ready;
            end
            if (pend && !(mem_wr_req && mem_wr_addr == p_addr && mem_wr_data == p_data))
                stab_err++;
            pend = mem_wr_req && !mem_wr_ack;
            p_addr = mem_wr_addr; p_data = mem_wr_data;
            if (pix_valid && pix_ready) begin
                exp_q.push_back(cur_pix);
                accepted++;
                cur_pix = seq_pix ? cur_pix + 24'd1 : 24'($urandom);
            end
            if (mem_wr_req && mem_wr_ack) begin
                obs_addr_q.push_back(mem_wr_addr);
                obs_data_q.push_back(mem_wr_data);
                if (first_ack < 0) first_ack = cyc;
                last_ack = cyc;
            end
            if (done) begin
                done_cnt++; done_cyc = cyc; busy_at_done = busy;
            end
            if (cfg_err) cfgerr_cnt++;
            @(posedge clk); #1;
            cyc++;
            if (done_cnt > 0 && cyc > done_cyc + 3) break;
        end
        idle_inputs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL reset_pix_ready got %b exp 0", pix_ready); end
        n_vec++; if (mem_wr_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b exp 0", mem_wr_req); end
        n_vec++; if (mem_wr_addr !== '0) begin n_err++; $display("FAIL reset_addr got %h exp 0", mem_wr_addr); end
        n_vec++; if (mem_wr_data !== '0) begin n_err++; $display("FAIL reset_data got %h exp 0", mem_wr_data); end
        n_vec++; if ({busy, done, cfg_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b exp 000", {busy, done, cfg_err}); end
        n_vec++; if (state_dbg !== FW_IDLE) begin n_err++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
`ifdef FRAME_WRITER_CHECKSUM_EN
        n_vec++; if (frame_checksum !== 32'd0) begin n_err++; $display("FAIL reset_checksum got %h exp 0", frame_checksum); end
`endif
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_2x3();
        drive_frame(2, 3, 'h100, 100, 100, 0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (ready_first !== 1'b1) begin n_err++; $display("FAIL basic_ready_first got %b exp 1", ready_first); end
        n_vec++; if (obs_addr_q.size() != 6) begin n_err++; $display("FAIL basic_nwrites got %0d exp 6", obs_addr_q.size()); end
        for (int k = 0; k < obs_addr_q.size() && k < 6; k++) begin
            n_vec++; if (obs_addr_q[k] !== ADDR_W'('h100 + k)) begin n_err++; $display("FAIL basic_addr[%0d] got %h exp %h", k, obs_addr_q[k], 'h100 + k); end
            n_vec++; if (obs_data_q[k] !== 24'(k + 1)) begin n_err++; $display("FAIL basic_data[%0d] got %h exp %h", k, obs_data_q[k], k + 1); end
        end
        n_vec++; if (first_ack != 1) begin n_err++; $display("FAIL basic_first_write_cycle got %0d exp 1", first_ack); end
        n_vec++; if (last_ack != 6) begin n_err++; $display("FAIL basic_throughput last_ack got %0d exp 6", last_ack); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL basic_done_count got %0d exp 1", done_cnt); end
        n_vec++; if (done_cyc != last_ack + 1) begin n_err++; $display("FAIL basic_done_cycle got %0d exp %0d", done_cyc, last_ack + 1); end
        n_vec++; if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done got %b exp 0", busy_at_done); end
`ifdef FRAME_WRITER_CHECKSUM_EN
        n_vec++; if (frame_checksum !== 32'h15) begin n_err++; $display("FAIL basic_checksum got %h exp 15", frame_checksum); end
`endif
    endtask

    task automatic test_stall_4x4();
        drive_frame(4, 4, 'h2000, 100, 100, 20, 1'b1, 1'b0, 1'b0);
        n_vec++; if (stall_accepts != 16) begin n_err++; $display("FAIL stall_accepts got %0d exp 16", stall_accepts); end
        n_vec++; if (ready_at_stall_end !== 1'b0) begin n_err++; $display("FAIL stall_ready got %b exp 0", ready_at_stall_end); end
        n_vec++; if (obs_addr_q.size() != 16) begin n_err++; $display("FAIL stall_nwrites got %0d exp 16", obs_addr_q.size()); end
        for (int k = 0; k < obs_addr_q.size() && k < exp_q.size(); k++) begin
            n_vec++; if (obs_addr_q[k] !== ADDR_W'('h2000 + k) || obs_data_q[k] !== exp_q[k]) begin
                n_err++; $display("FAIL stall_write[%0d] got %h/%h exp %h/%h", k, obs_addr_q[k], obs_data_q[k], 'h2000 + k, exp_q[k]); end
        end
        n_vec++; if (stab_err != 0) begin n_err++; $display("FAIL stall_hold_stable got %0d exp 0", stab_err); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL stall_done got %0d exp 1", done_cnt); end
    endtask

    task automatic test_cfg_err();
        for (int i = 0; i < 2; i++) begin
            int req_seen = 0;
            @(posedge clk); #1;
            start = 1'b1; img_height = (i == 0) ? DIM_W'(3) : DIM_W'(0); img_width = (i == 0) ? DIM_W'(0) : DIM_W'(5);
            mem_wr_ack = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_err_pulse[%0d] got %b exp 1", i, cfg_err); end
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cfg_err_busy[%0d] got %b exp 0", i, busy); end
            @(posedge clk); #1;
            n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfg_err_width[%0d] got %b exp 0", i, cfg_err); end
            for (int c = 0; c < 4; c++) begin
                if (mem_wr_req || busy) req_seen++;
                @(posedge clk); #1;
            end
            n_vec++; if (req_seen != 0) begin n_err++; $display("FAIL cfg_err_activity[%0d] got %0d exp 0", i, req_seen); end
        end
        idle_inputs();
    endtask

    task automatic test_start_in_run();
        drive_frame(3, 3, 'h40, 100, 60, 0, 1'b1, 1'b1, 1'b0);
        n_vec++; if (accepted != 9) begin n_err++; $display("FAIL sir_accepted got %0d exp 9", accepted); end
        n_vec++; if (obs_addr_q.size() != 9) begin n_err++; $display("FAIL sir_nwrites got %0d exp 9", obs_addr_q.size()); end
        for (int k = 0; k < obs_addr_q.size() && k < exp_q.size(); k++) begin
            n_vec++; if (obs_addr_q[k] !== ADDR_W'('h40 + k) || obs_data_q[k] !== exp_q[k]) begin
                n_err++; $display("FAIL sir_write[%0d] got %h/%h exp %h/%h", k, obs_addr_q[k], obs_data_q[k], 'h40 + k, exp_q[k]); end
        end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL sir_done got %0d exp 1", done_cnt); end
    endtask

    task automatic test_addr_wrap();
        logic [ADDR_W-1:0] exp_a[4];
        exp_a[0] = 20'hFFFFE; exp_a[1] = 20'hFFFFF; exp_a[2] = 20'h00000; exp_a[3] = 20'h00001;
        drive_frame(1, 4, 'hFFFFE, 100, 100, 0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (obs_addr_q.size() != 4) begin n_err++; $display("FAIL wrap_nwrites got %0d exp 4", obs_addr_q.size()); end
        for (int k = 0; k < obs_addr_q.size() && k < 4; k++) begin
            n_vec++; if (obs_addr_q[k] !== exp_a[k]) begin n_err++; $display("FAIL wrap_addr[%0d] got %h exp %h", k, obs_addr_q[k], exp_a[k]); end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 5; t++) begin
            int h = $urandom_range(1, 5);
            int w = $urandom_range(1, 6);
            int base = int'($urandom_range(0, 20'hFFFFF));
            logic [31:0] sum = 0;
            drive_frame(h, w, base, $urandom_range(30, 100), $urandom_range(30, 100), 0, 1'b0, 1'b0, 1'b0);
            n_vec++; if (obs_addr_q.size() != h * w) begin n_err++; $display("FAIL rand%0d_nwrites got %0d exp %0d", t, obs_addr_q.size(), h * w); end
            for (int k = 0; k < obs_addr_q.size() && k < exp_q.size(); k++) begin
                n_vec++; if (obs_addr_q[k] !== ADDR_W'(base + k) || obs_data_q[k] !== exp_q[k]) begin
                    n_err++; $display("FAIL rand%0d_write[%0d] got %h/%h exp %h/%h", t, k, obs_addr_q[k], obs_data_q[k], ADDR_W'(base + k), exp_q[k]); end
            end
            foreach (exp_q[k]) sum += {8'd0, exp_q[k]};
            n_vec++; if (stab_err != 0) begin n_err++; $display("FAIL rand%0d_hold_stable got %0d exp 0", t, stab_err); end
            n_vec++; if (done_cnt != 1 || done_cyc != last_ack + 1) begin
                n_err++; $display("FAIL rand%0d_done got cnt %0d cyc %0d exp cnt 1 cyc %0d", t, done_cnt, done_cyc, last_ack + 1); end
`ifdef FRAME_WRITER_CHECKSUM_EN
            n_vec++; if (frame_checksum !== sum) begin n_err++; $display("FAIL rand%0d_checksum got %h exp %h", t, frame_checksum, sum); end
`endif
        end
    endtask

    task automatic test_reset_midframe();
        int pushes = 0;
        @(posedge clk); #1;
        start = 1'b1; img_height = DIM_W'(8); img_width = DIM_W'(8); base_addr = ADDR_W'('h500);
        @(posedge clk); #1;
        start = 1'b0;
        while (pushes < 5) begin
            pix_valid = 1'b1; color_in = 24'($urandom); mem_wr_ack = 1'b0;
            if (pix_ready) pushes++;
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++; if ({pix_ready, mem_wr_req, busy, done, cfg_err} !== 5'b0) begin
            n_err++; $display("FAIL midrst_flags got %b exp 00000", {pix_ready, mem_wr_req, busy, done, cfg_err}); end
        n_vec++; if (mem_wr_addr !== '0 || mem_wr_data !== '0) begin
            n_err++; $display("FAIL midrst_bus got %h/%h exp 0/0", mem_wr_addr, mem_wr_data); end
        reset = 1'b0;
        drive_frame(1, 1, 'h77, 100, 100, 0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (obs_addr_q.size() != 1) begin n_err++; $display("FAIL midrst_nwrites got %0d exp 1", obs_addr_q.size()); end
        if (obs_addr_q.size() > 0 && exp_q.size() > 0) begin
            n_vec++; if (obs_addr_q[0] !== ADDR_W'('h77) || obs_data_q[0] !== exp_q[0]) begin
                n_err++; $display("FAIL midrst_write got %h/%h exp 77/%h", obs_addr_q[0], obs_data_q[0], exp_q[0]); end
        end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL midrst_done got %0d exp 1", done_cnt); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_basic_2x3();
        test_stall_4x4();
        test_cfg_err();
        test_start_in_run();
        test_addr_wrap();
        test_random();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
